// File: rtl/jump_base_resolver_if.sv
// jump_base_resolver_if: jump-base request, register-file read and writeback bus bundle
interface jump_base_resolver_if #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4,
   parameter int TAG_W  = 6,
   parameter int NUM_WB = 2,
   parameter int CNT_W  = 8
);
   logic                     has_mispredict;
   logic                     req_valid;
   logic [REG_W-1:0]         req_reg;
   logic                     req_ready;
   logic [REG_W-1:0]         rf_rd_addr;
   logic [DATA_W-1:0]        rf_rd_data;
   logic                     rf_rd_busy;
   logic [TAG_W-1:0]         rf_rd_tag;
   logic [NUM_WB-1:0]        wb_valid;
   logic [NUM_WB*TAG_W-1:0]  wb_tag;
   logic [NUM_WB*DATA_W-1:0] wb_data;
   logic [DATA_W-1:0]        jump_base_out;
   logic                     jump_base_rdy;
   logic [CNT_W-1:0]         wait_cycles;
   modport slave (
      input  has_mispredict, req_valid, req_reg, rf_rd_data, rf_rd_busy, rf_rd_tag,
             wb_valid, wb_tag, wb_data,
      output req_ready, rf_rd_addr, jump_base_out, jump_base_rdy, wait_cycles
   );
   modport master (
      output has_mispredict, req_valid, req_reg, rf_rd_data, rf_rd_busy, rf_rd_tag,
             wb_valid, wb_tag, wb_data,
      input  req_ready, rf_rd_addr, jump_base_out, jump_base_rdy, wait_cycles
   );
endinterface

// File: rtl/jump_base_resolver.sv
// jump_base_resolver: resolves a jump base register, waiting on writeback when in flight
module jump_base_resolver #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 4,
   parameter int TAG_W  = 6,
   parameter int NUM_WB = 2,
   parameter int CNT_W  = 8
) (
   input logic clk,
   input logic rst,
   jump_base_resolver_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_WB, RESP} state_t;
   state_t            state_q;
   logic [REG_W-1:0]  addr_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] out_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [TAG_W-1:0]  cmp_tag;
   logic              hit;
   logic [DATA_W-1:0] hit_data;
   assign cmp_tag = state_q == LOOKUP ? bus.rf_rd_tag : tag_q;
   // descending scan so the lowest matching port is the one left standing
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int i = NUM_WB - 1; i >= 0; i--)
         if (bus.wb_valid[i] && bus.wb_tag[i*TAG_W +: TAG_W] == cmp_tag) begin
            hit      = 1'b1;
            hit_data = bus.wb_data[i*DATA_W +: DATA_W];
         end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         tag_q   <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
      end else if (bus.has_mispredict) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: if (bus.req_valid) begin
               addr_q <= bus.req_reg;
               cnt_q  <= '0;
               if (bus.req_reg == '0) begin
                  out_q   <= '0;
                  state_q <= RESP;
               end else state_q <= LOOKUP;
            end
            LOOKUP: if (!bus.rf_rd_busy) begin
               out_q   <= bus.rf_rd_data;
               state_q <= RESP;
            end else if (hit) begin
               out_q   <= hit_data;
               state_q <= RESP;
            end else begin
               tag_q   <= bus.rf_rd_tag;
               state_q <= WAIT_WB;
            end
            WAIT_WB: if (hit) begin
               out_q   <= hit_data;
               state_q <= RESP;
            end else cnt_q <= &cnt_q ? cnt_q : cnt_q + 1'b1;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.req_ready     = state_q == IDLE && !bus.has_mispredict;
   assign bus.jump_base_rdy = state_q == RESP && !bus.has_mispredict;
   assign bus.rf_rd_addr    = addr_q;
   assign bus.jump_base_out = out_q;
   assign bus.wait_cycles   = cnt_q;
endmodule

// File: tb/tb_jump_base_resolver.sv
// tb_jump_base_resolver: scenario tasks with a pulse scoreboard for jump_base_resolver
module tb_jump_base_resolver;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int tests = 0;
   int fails = 0;
   logic [15:0] exp_q[$];
   logic [15:0] rf_val[16];
   logic        rf_busy[16];
   logic [5:0]  rf_tag[16];
   jump_base_resolver_if bus ();
   jump_base_resolver dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   assign bus.rf_rd_data = rf_val[bus.rf_rd_addr];
   assign bus.rf_rd_busy = rf_busy[bus.rf_rd_addr];
   assign bus.rf_rd_tag  = rf_tag[bus.rf_rd_addr];
   // every pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && bus.jump_base_rdy) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse: got pulse with data %h, required no pulse", bus.jump_base_out);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            if (bus.jump_base_out !== e) begin
               fails++;
               $display("FAIL pulse_data: got %h, required %h", bus.jump_base_out, e);
            end
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wb_set(input logic [1:0] v, input logic [5:0] t0, input logic [5:0] t1,
                         input logic [15:0] d0, input logic [15:0] d1);
      bus.wb_valid = v;
      bus.wb_tag   = {t1, t0};
      bus.wb_data  = {d1, d0};
   endtask
   task automatic issue(input logic [3:0] r);
      bus.req_valid = 1'b1;
      bus.req_reg   = r;
      #1;
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL req_ready_idle: got %b, required 1", bus.req_ready);
      end
      tick();
      bus.req_valid = 1'b0;
   endtask
   task automatic wait_rdy(input int lat, input string name);
      int n;
      n = 1;
      while (!bus.jump_base_rdy && n < 12) begin
         tick();
         n++;
      end
      tests++;
      if (!bus.jump_base_rdy || n != lat) begin
         fails++;
         $display("FAIL %s_latency: got %0d cycles (rdy=%b), required %0d", name, n, bus.jump_base_rdy, lat);
      end
   endtask
   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tests++;
      if ({bus.req_ready, bus.rf_rd_addr, bus.jump_base_out, bus.jump_base_rdy, bus.wait_cycles} !== {1'b1, 4'h0, 16'h0, 1'b0, 8'h0}) begin
         fails++;
         $display("FAIL reset_state: got ready=%b addr=%h out=%h rdy=%b wait=%0d, required 1/0/0/0/0",
                  bus.req_ready, bus.rf_rd_addr, bus.jump_base_out, bus.jump_base_rdy, bus.wait_cycles);
      end
   endtask
   task automatic test_ready_reg();
      rf_val[3] = 16'h1234;
      exp_q.push_back(16'h1234);
      issue(4'd3);
      tests++;
      if (bus.rf_rd_addr !== 4'd3) begin
         fails++;
         $display("FAIL rd_addr: got %h, required 3", bus.rf_rd_addr);
      end
      wait_rdy(2, "ready_reg");
      tests++;
      if (bus.wait_cycles !== 8'd0) begin
         fails++;
         $display("FAIL ready_wait_cycles: got %0d, required 0", bus.wait_cycles);
      end
      tick();
   endtask
   task automatic test_r0();
      rf_val[0] = 16'hFFFF;
      exp_q.push_back(16'h0000);
      issue(4'd0);
      wait_rdy(1, "r0");
      tick();
   endtask
   task automatic test_inflight();
      rf_busy[6] = 1'b1;
      rf_tag[6]  = 6'h15;
      exp_q.push_back(16'hBEEF);
      issue(4'd6);
      tick();
      for (int k = 0; k < 5; k++) begin
         wb_set(k == 2 ? 2'b01 : 2'b00, 6'h16, 6'h00, 16'hDEAD, 16'h0);
         tick();
      end
      wb_set(2'b11, 6'h14, 6'h15, 16'hDEAD, 16'hBEEF);
      tests++;
      if (bus.wait_cycles !== 8'd5) begin
         fails++;
         $display("FAIL inflight_wait_cycles: got %0d, required 5", bus.wait_cycles);
      end
      tick();
      wb_set(2'b00, 6'h0, 6'h0, 16'h0, 16'h0);
      tests++;
      if (bus.jump_base_rdy !== 1'b1 || bus.wait_cycles !== 8'd5) begin
         fails++;
         $display("FAIL inflight_resp: got rdy=%b wait=%0d, required rdy=1 wait=5", bus.jump_base_rdy, bus.wait_cycles);
      end
      tick();
   endtask
   task automatic test_bypass_priority();
      rf_busy[7] = 1'b1;
      rf_tag[7]  = 6'h07;
      exp_q.push_back(16'h1111);
      issue(4'd7);
      wb_set(2'b11, 6'h07, 6'h07, 16'h1111, 16'h2222);
      tick();
      wb_set(2'b00, 6'h0, 6'h0, 16'h0, 16'h0);
      tests++;
      if (bus.jump_base_rdy !== 1'b1) begin
         fails++;
         $display("FAIL bypass_latency: got rdy=%b at N+2, required 1", bus.jump_base_rdy);
      end
      tick();
   endtask
   task automatic test_flush();
      rf_busy[8] = 1'b1;
      rf_tag[8]  = 6'h20;
      issue(4'd8);
      tick();
      bus.has_mispredict = 1'b1;
      tick();
      bus.has_mispredict = 1'b0;
      #1;
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_wait_ready: got %b, required 1", bus.req_ready);
      end
      wb_set(2'b01, 6'h20, 6'h0, 16'h5555, 16'h0);
      tick();
      wb_set(2'b00, 6'h0, 6'h0, 16'h0, 16'h0);
      rf_val[5] = 16'h00AA;
      exp_q.push_back(16'h00AA);
      issue(4'd5);
      wait_rdy(2, "after_flush");
      tick();
      rf_val[9] = 16'h0999;
      issue(4'd9);
      tick();
      bus.has_mispredict = 1'b1;
      #1;
      tests++;
      if (bus.jump_base_rdy !== 1'b0) begin
         fails++;
         $display("FAIL flush_resp_pulse: got rdy=%b, required 0", bus.jump_base_rdy);
      end
      tick();
      bus.has_mispredict = 1'b0;
      #1;
      tests++;
      if (bus.req_ready !== 1'b1) begin
         fails++;
         $display("FAIL flush_resp_ready: got %b, required 1", bus.req_ready);
      end
      tick();
   endtask
   task automatic test_backpressure();
      rf_busy[10] = 1'b1;
      rf_tag[10]  = 6'h2A;
      exp_q.push_back(16'hCAFE);
      issue(4'd10);
      bus.req_valid = 1'b1;
      bus.req_reg   = 4'd3;
      for (int k = 0; k < 3; k++) begin
         tick();
         tests++;
         if (bus.req_ready !== 1'b0) begin
            fails++;
            $display("FAIL busy_ready: got %b in cycle %0d, required 0", bus.req_ready, k);
         end
      end
      wb_set(2'b01, 6'h2A, 6'h0, 16'hCAFE, 16'h0);
      tick();
      wb_set(2'b00, 6'h0, 6'h0, 16'h0, 16'h0);
      bus.req_valid = 1'b0;
      tests++;
      if (bus.jump_base_rdy !== 1'b1 || bus.wait_cycles !== 8'd2) begin
         fails++;
         $display("FAIL backpressure_resp: got rdy=%b wait=%0d, required rdy=1 wait=2", bus.jump_base_rdy, bus.wait_cycles);
      end
      tick();
      tick();
   endtask
   task automatic test_saturate();
      rf_busy[12] = 1'b1;
      rf_tag[12]  = 6'h3F;
      issue(4'd12);
      for (int k = 0; k < 300; k++) tick();
      tests++;
      if (bus.wait_cycles !== 8'hFF) begin
         fails++;
         $display("FAIL wait_saturate: got %0d, required 255", bus.wait_cycles);
      end
      bus.has_mispredict = 1'b1;
      tick();
      bus.has_mispredict = 1'b0;
      tick();
   endtask
   task automatic test_reset_mid();
      rf_busy[11] = 1'b1;
      rf_tag[11]  = 6'h30;
      issue(4'd11);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests++;
      if ({bus.req_ready, bus.rf_rd_addr, bus.jump_base_out, bus.jump_base_rdy, bus.wait_cycles} !== {1'b1, 4'h0, 16'h0, 1'b0, 8'h0}) begin
         fails++;
         $display("FAIL reset_mid: got ready=%b addr=%h out=%h rdy=%b wait=%0d, required 1/0/0/0/0",
                  bus.req_ready, bus.rf_rd_addr, bus.jump_base_out, bus.jump_base_rdy, bus.wait_cycles);
      end
      wb_set(2'b01, 6'h30, 6'h0, 16'h7777, 16'h0);
      tick();
      wb_set(2'b00, 6'h0, 6'h0, 16'h0, 16'h0);
      for (int k = 0; k < 4; k++) tick();
   endtask
   initial begin
      for (int k = 0; k < 16; k++) begin
         rf_val[k]  = 16'(k * 16'h0101);
         rf_busy[k] = 1'b0;
         rf_tag[k]  = '0;
      end
      bus.has_mispredict = 1'b0;
      bus.req_valid      = 1'b0;
      bus.req_reg        = '0;
      wb_set(2'b00, 6'h0, 6'h0, 16'h0, 16'h0);
      test_reset();
      test_ready_reg();
      test_r0();
      test_inflight();
      test_bypass_priority();
      test_flush();
      test_backpressure();
      test_saturate();
      test_reset_mid();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL missing_pulses: got %0d outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/jump_base_resolver.md
Name: jump_base_resolver

Overview:
- Responder side of the register-based jump handshake. Accepts a base-register jump request from the fetch-stage jump handler.
- Reads the architectural register file and rename busy state. If the register is in flight, waits for the matching writeback broadcast.
- Returns the 16-bit base value with a one-cycle ready pulse. Sits between decode/rename and fetch; aborts on branch mispredict.

Parameters:
- DATA_W, 16, width of register value and returned jump base
- REG_W, 4, architectural register index width (16 registers)
- TAG_W, 6, physical-register/ROB tag width used on writeback broadcast
- NUM_WB, 2, number of writeback broadcast ports
- CNT_W, 8, width of wait-cycle performance counter

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- has_mispredict  input  1  flush; abandons any outstanding request
- req_valid  input  1  base-register jump request valid
- req_reg  input  REG_W  base register index
- req_ready  output  1  high only in IDLE; a request is accepted when req_valid & req_ready
- rf_rd_addr  output  REG_W  register file / busy-table read address (registered)
- rf_rd_data  input  DATA_W  committed value at rf_rd_addr (combinational read)
- rf_rd_busy  input  1  register has an in-flight producer
- rf_rd_tag  input  TAG_W  producer tag when busy
- wb_valid  input  NUM_WB  per-port writeback valid
- wb_tag  input  NUM_WB*TAG_W  packed writeback tags, port 0 in LSBs
- wb_data  input  NUM_WB*DATA_W  packed writeback data, port 0 in LSBs
- jump_base_out  output  DATA_W  resolved base value, valid while jump_base_rdy
- jump_base_rdy  output  1  one-cycle pulse, base available
- wait_cycles  output  CNT_W  cycles spent in WAIT_WB for the last/current request, saturating

Behaviour:
- Reset: state IDLE; req_ready=1 from the first cycle after reset. rf_rd_addr=0, jump_base_out=0, jump_base_rdy=0, wait_cycles=0, captured tag=0. A reset mid-request discards the request with no pulse.
- FSM states: IDLE, LOOKUP, WAIT_WB, RESP.
- IDLE: on accept, rf_rd_addr<=req_reg, wait_cycles<=0.
  - req_reg==0: r0 reads as zero. Go directly to RESP with data 0.
  - Otherwise go to LOOKUP.
- LOOKUP (one cycle, samples read port):
  - rf_rd_busy=0: capture rf_rd_data, go to RESP.
  - rf_rd_busy=1 and some wb port valid with wb_tag==rf_rd_tag this cycle: bypass. Capture that wb_data, go to RESP.
  - Else capture rf_rd_tag, go to WAIT_WB.
- WAIT_WB: each cycle, compare the captured tag against every valid wb port.
  - On match, capture data and go to RESP. If several ports match, the lowest index wins.
  - With no match, increment wait_cycles, saturating at all-ones. No timeout.
- RESP: jump_base_rdy=1 and jump_base_out=captured data for exactly this cycle. Next state IDLE.
  - jump_base_out holds its value after the pulse until the next RESP.
- Latency, req accept at cycle N:
  - Ready register: rdy at N+2.
  - r0: rdy at N+1.
  - Busy register: rdy one cycle after the matching writeback.
- Flush: has_mispredict in any state forces IDLE next cycle, with no rdy pulse and no accept that cycle. Flush beats a same-cycle req_valid, and beats RESP (pulse suppressed).
- req_valid while req_ready=0 is ignored, not queued. The requester holds or re-issues.
- A writeback whose tag does not match has no effect. A writeback in the same cycle as accept (IDLE) is not observed; it is covered by the rename busy bit clearing in the register file.
- Tag comparison is exact, all TAG_W bits; no wrap handling required.

Test Plan:
- Ready register: rst 2 cycles; req r3 with rf_rd_busy=0, rf_rd_data=0x1234 -> jump_base_rdy pulses once at N+2 with jump_base_out=0x1234; wait_cycles=0.
- r0 request: req_reg=0 -> rdy at N+1 with data 0x0000; rf_rd_data is ignored.
- In-flight register: busy=1, tag=0x15; after 5 idle cycles, wb port1 valid, tag 0x15, data 0xBEEF -> rdy next cycle, data 0xBEEF, wait_cycles=5.
- LOOKUP bypass and priority: tag 0x07 with both wb ports matching, data 0x1111 (port0) and 0x2222 (port1) in LOOKUP -> rdy at N+2 with 0x1111.
- Flush: enter WAIT_WB, assert has_mispredict -> no rdy ever. req_ready=1 next cycle; a new req r5 (ready, 0x00AA) completes normally. Repeat with the flush landing on the RESP cycle -> pulse suppressed.
- Backpressure/reset: req_valid held high during WAIT_WB -> ignored and only one rdy pulse. Assert rst mid-WAIT_WB -> all outputs 0 next cycle and no pulse.
